// File: rtl/mod_counter_pkg.sv
// Shared constants for the modulo counter and the LED snake grid logic that sizes from it.
// Holds boundary-mode encodings, default geometry and an elaboration-time config check.
package mod_counter_pkg;

   localparam int MODE_WRAP = 0;
   localparam int MODE_SAT  = 1;

   localparam int DEF_WIDTH   = 5;
   localparam int DEF_CNT_MAX = 24;
   localparam int DEF_DIV     = 1;

   // Widened to longint so WIDTH up to 62 does not overflow the 2**WIDTH-1 bound.
   function automatic bit cfg_ok(input int width, input int cnt_max, input int div);
      longint lim;
      lim = (longint'(1) <<< width) - 1;
      return (width >= 1) && (cnt_max >= 1) && (longint'(cnt_max) <= lim) && (div >= 1);
   endfunction

endpackage

// File: rtl/mod_counter_tick_gen.sv
// Prescaler: pulses tick on every DIV-th enabled cycle; sclr restarts the phase.
// tick is combinational from the registered phase and en; there is no backpressure.
module tick_gen #(
   parameter int DIV = 1
) (
   input  logic clk,
   input  logic rstn,
   input  logic en,
   input  logic sclr,
   output logic tick
);

   localparam int            PW   = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [PW-1:0] LAST = PW'(DIV - 1);

   logic [PW-1:0] r_pre;
   logic          w_last;

   assign w_last = (r_pre == LAST);
   assign tick   = en & w_last;

   // With DIV = 1 the phase never leaves 0, so tick degenerates to en.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_pre <= '0;
      end else if (sclr) begin
         r_pre <= '0;
      end else if (en) begin
         r_pre <= w_last ? '0 : r_pre + PW'(1);
      end
   end

endmodule

// File: rtl/mod_counter.sv
// Up/down modulo counter with clear/load, prescaled stepping and wrap or saturate boundaries.
// cnt/ovf/unf update one clock after the qualifying edge inputs; tc is combinational; no backpressure.
module mod_counter
   import mod_counter_pkg::*;
#(
   parameter int WIDTH    = DEF_WIDTH,
   parameter int CNT_MAX  = DEF_CNT_MAX,
   parameter int SATURATE = MODE_WRAP,
   parameter int DIV      = DEF_DIV
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             en,
   input  logic             clr,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             up,
   output logic [WIDTH-1:0] cnt,
   output logic             ovf,
   output logic             unf,
   output logic             tc
);

   if (!cfg_ok(WIDTH, CNT_MAX, DIV)) begin : g_bad_cfg
      $error("mod_counter: illegal parameters WIDTH=%0d CNT_MAX=%0d DIV=%0d", WIDTH, CNT_MAX, DIV);
   end

   localparam logic [WIDTH-1:0] MAX_V = WIDTH'(CNT_MAX);
   localparam bit               SAT   = (SATURATE == MODE_SAT);

   logic [WIDTH-1:0] r_cnt;
   logic             r_ovf;
   logic             r_unf;
   logic             w_tick;
   logic             w_sclr;
   logic             w_step;
   logic             w_at_max;
   logic             w_at_zero;
   logic [WIDTH-1:0] w_load_val;

   assign w_sclr     = clr | load;
   assign w_step     = en & w_tick & ~w_sclr;
   assign w_at_max   = (r_cnt == MAX_V);
   assign w_at_zero  = (r_cnt == '0);
   assign w_load_val = (load_val > MAX_V) ? MAX_V : load_val;

   tick_gen #(
      .DIV (DIV)
   ) u_tick_gen (
      .clk  (clk),
      .rstn (rstn),
      .en   (en),
      .sclr (w_sclr),
      .tick (w_tick)
   );

   // Pulses default low every edge so they last exactly one cycle alongside the new count.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_cnt <= '0;
         r_ovf <= 1'b0;
         r_unf <= 1'b0;
      end else begin
         r_ovf <= 1'b0;
         r_unf <= 1'b0;
         if (clr) begin
            r_cnt <= '0;
         end else if (load) begin
            r_cnt <= w_load_val;
         end else if (w_step) begin
            if (up) begin
               if (w_at_max) begin
                  r_ovf <= 1'b1;
                  r_cnt <= SAT ? r_cnt : '0;
               end else begin
                  r_cnt <= r_cnt + WIDTH'(1);
               end
            end else begin
               if (w_at_zero) begin
                  r_unf <= 1'b1;
                  r_cnt <= SAT ? r_cnt : MAX_V;
               end else begin
                  r_cnt <= r_cnt - WIDTH'(1);
               end
            end
         end
      end
   end

   assign cnt = r_cnt;
   assign ovf = r_ovf;
   assign unf = r_unf;
   assign tc  = up ? w_at_max : w_at_zero;

endmodule

// File: tb/tb_mod_counter.sv
// Directed bench: wrap/DIV=1, saturate/DIV=1 and wrap/DIV=4 counters side by side.
module tb_mod_counter;

   logic clk;
   logic rstn;

   logic       a_en, a_clr, a_load, a_up;
   logic [4:0] a_load_val, a_cnt;
   logic       a_ovf, a_unf, a_tc;

   logic       s_en, s_clr, s_load, s_up;
   logic [4:0] s_load_val, s_cnt;
   logic       s_ovf, s_unf, s_tc;

   logic       d_en, d_clr, d_load, d_up;
   logic [4:0] d_load_val, d_cnt;
   logic       d_ovf, d_unf, d_tc;

   int n_chk;
   int n_fail;

   mod_counter u_wrap (
      .clk(clk), .rstn(rstn), .en(a_en), .clr(a_clr), .load(a_load), .load_val(a_load_val),
      .up(a_up), .cnt(a_cnt), .ovf(a_ovf), .unf(a_unf), .tc(a_tc)
   );

   mod_counter #(.SATURATE(1)) u_sat (
      .clk(clk), .rstn(rstn), .en(s_en), .clr(s_clr), .load(s_load), .load_val(s_load_val),
      .up(s_up), .cnt(s_cnt), .ovf(s_ovf), .unf(s_unf), .tc(s_tc)
   );

   mod_counter #(.DIV(4)) u_div (
      .clk(clk), .rstn(rstn), .en(d_en), .clr(d_clr), .load(d_load), .load_val(d_load_val),
      .up(d_up), .cnt(d_cnt), .ovf(d_ovf), .unf(d_unf), .tc(d_tc)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      n_chk  = 0;
      n_fail = 0;
      rstn = 1'b0;
      {a_en, a_clr, a_load, a_up, a_load_val} = '0;
      {s_en, s_clr, s_load, s_up, s_load_val} = '0;
      {d_en, d_clr, d_load, d_up, d_load_val} = '0;

      // Reset state, sampled between edges
      #12;
      check("rst_cnt", a_cnt, 0);
      check("rst_ovf", a_ovf, 0);
      check("rst_unf", a_unf, 0);
      check("rst_tc_down", a_tc, 1);
      check("rst_sat_cnt", s_cnt, 0);
      check("rst_div_cnt", d_cnt, 0);
      rstn = 1'b1;

      // Free-running up count through the wrap
      a_up = 1'b1;
      a_en = 1'b1;
      for (int i = 1; i <= 26; i++) begin
         tick();
         check("wrap_cnt", a_cnt, i % 25);
         check("wrap_ovf", a_ovf, (i == 25) ? 1 : 0);
         if (i == 24) check("wrap_tc_at_max", a_tc, 1);
      end
      a_en  = 1'b0;
      a_clr = 1'b1;
      tick();
      check("clr_cnt", a_cnt, 0);
      check("clr_no_ovf", a_ovf, 0);
      a_clr = 1'b0;

      // Down-step at 0 wraps to max; tc follows up combinationally
      a_up = 1'b0;
      a_en = 1'b1;
      tick();
      check("dn_wrap_cnt", a_cnt, 24);
      check("dn_wrap_unf", a_unf, 1);
      check("dn_wrap_tc", a_tc, 0);
      a_up = 1'b1;
      a_en = 1'b0;
      #1;
      check("dir_tc_same_cycle", a_tc, 1);
      tick();
      check("unf_one_cycle", a_unf, 0);
      check("hold_cnt", a_cnt, 24);

      // Load clamps; clr beats load; load beats step
      a_load     = 1'b1;
      a_load_val = 5'd31;
      tick();
      check("load_clamp_cnt", a_cnt, 24);
      check("load_no_ovf", a_ovf, 0);
      check("load_no_unf", a_unf, 0);
      a_clr = 1'b1;
      tick();
      check("clr_over_load_cnt", a_cnt, 0);
      check("clr_over_load_ovf", a_ovf, 0);
      check("clr_over_load_unf", a_unf, 0);
      a_clr      = 1'b0;
      a_load_val = 5'd5;
      a_en       = 1'b1;
      tick();
      check("load_over_step", a_cnt, 5);
      a_load = 1'b0;
      tick();
      check("step_after_load", a_cnt, 6);
      a_en = 1'b0;

      // Saturate mode: repeated boundary steps hold and re-pulse
      s_up = 1'b0;
      s_en = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("sat_dn_cnt", s_cnt, 0);
         check("sat_dn_unf", s_unf, 1);
         check("sat_dn_tc", s_tc, 1);
      end
      s_en = 1'b0;
      tick();
      check("sat_unf_drop", s_unf, 0);
      s_load     = 1'b1;
      s_load_val = 5'd24;
      tick();
      check("sat_load", s_cnt, 24);
      s_load = 1'b0;
      s_up   = 1'b1;
      s_en   = 1'b1;
      for (int i = 0; i < 2; i++) begin
         tick();
         check("sat_up_cnt", s_cnt, 24);
         check("sat_up_ovf", s_ovf, 1);
      end
      s_up = 1'b0;
      tick();
      check("sat_leave_cnt", s_cnt, 23);
      check("sat_leave_ovf", s_ovf, 0);
      s_en = 1'b0;

      // Prescaler DIV=4: steps on enabled cycles 4, 8, 12
      d_up = 1'b1;
      d_en = 1'b1;
      for (int i = 1; i <= 12; i++) begin
         tick();
         check("div_cnt", d_cnt, i / 4);
      end
      tick();
      tick();
      check("div_mid_phase", d_cnt, 3);
      d_up = 1'b0;
      tick();
      check("div_dir_wait", d_cnt, 3);
      tick();
      check("div_dir_step", d_cnt, 2);
      d_en = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("div_en_hold", d_cnt, 2);
      end
      d_en = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         tick();
         check("div_resume", d_cnt, (i == 4) ? 1 : 2);
      end
      tick();
      tick();
      d_clr = 1'b1;
      tick();
      check("div_clr", d_cnt, 0);
      d_clr = 1'b0;
      d_up  = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         tick();
         check("div_clr_phase", d_cnt, (i == 4) ? 1 : 0);
      end
      d_en = 1'b0;

      // Asynchronous reset mid-count
      a_load     = 1'b1;
      a_load_val = 5'd17;
      tick();
      check("pre_rst_cnt", a_cnt, 17);
      a_load = 1'b0;
      #2;
      rstn = 1'b0;
      #1;
      check("async_rst_cnt", a_cnt, 0);
      check("async_rst_ovf", a_ovf, 0);
      check("async_rst_div", d_cnt, 0);
      #3;
      rstn = 1'b1;
      a_up = 1'b1;
      a_en = 1'b1;
      tick();
      check("post_rst_cnt", a_cnt, 1);
      check("post_rst_ovf", a_ovf, 0);
      a_en = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
